// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - W-stage bus: memory-stage inputs, decode read port, W register and status outputs
interface writeback_stage_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       m_stat;
  logic [3:0]       m_icode;
  logic [63:0]      m_valE;
  logic [63:0]      m_valM;
  logic [3:0]       m_dstE;
  logic [3:0]       m_dstM;
  logic             W_stall;
  logic             W_bubble;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [63:0]      d_rvalA;
  logic [63:0]      d_rvalB;
  logic [3:0]       W_stat;
  logic [3:0]       W_icode;
  logic [63:0]      W_valE;
  logic [63:0]      W_valM;
  logic [3:0]       W_dstE;
  logic [3:0]       W_dstM;
  logic [3:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
    output W_stall, W_bubble, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB,
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
    input  stat, halted, retire_cnt
  );

  modport slave (
    input  m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
    input  W_stall, W_bubble, d_srcA, d_srcB,
    output d_rvalA, d_rvalB,
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
    output stat, halted, retire_cnt
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - Y86-64 W pipeline register, 15-entry register file, sticky halt and retire counter
// Optional feature macro: REG_RSP_INIT_EN (reset loads %rsp with STACK_TOP).
module writeback_stage #(
  parameter logic [63:0] STACK_TOP = 64'd4000,
  parameter int          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_stage_if.slave  wb
);

  localparam logic [3:0] AOK   = 4'b0001;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] I_NOP = 4'h1;

`ifdef REG_RSP_INIT_EN
  localparam logic RSP_INIT = 1'b1;
`else
  localparam logic RSP_INIT = 1'b0;
`endif
  localparam logic [63:0] RSP_RESET = STACK_TOP & {64{RSP_INIT}};

  logic [3:0]       r_stat;
  logic [3:0]       r_icode;
  logic [63:0]      r_valE;
  logic [63:0]      r_valM;
  logic [3:0]       r_dstE;
  logic [3:0]       r_dstM;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_rf [0:14];

  logic w_wr_ok;
  logic w_freeze;

  assign w_wr_ok  = (r_stat == AOK) && !r_halted;
  // Freeze already on the halting edge so stat keeps showing the faulting code.
  assign w_freeze = r_halted || (r_stat != AOK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat   <= AOK;
      r_icode  <= I_NOP;
      r_valE   <= 64'd0;
      r_valM   <= 64'd0;
      r_dstE   <= RNONE;
      r_dstM   <= RNONE;
      r_halted <= 1'b0;
      r_cnt    <= '0;
      for (int i = 0; i < 15; i++) begin
        r_rf[i] <= (i == 4) ? RSP_RESET : 64'd0;
      end
    end else begin
      // Port M is written last so it wins on dstE == dstM (popq %rsp).
      if (w_wr_ok && r_dstE != RNONE) r_rf[r_dstE] <= r_valE;
      if (w_wr_ok && r_dstM != RNONE) r_rf[r_dstM] <= r_valM;

      if (!r_halted && r_stat != AOK) r_halted <= 1'b1;

      if (w_wr_ok && r_icode != I_NOP) r_cnt <= r_cnt + CNT_W'(1);

      if (!w_freeze) begin
        if (wb.W_bubble) begin
          r_stat  <= AOK;
          r_icode <= I_NOP;
          r_valE  <= 64'd0;
          r_valM  <= 64'd0;
          r_dstE  <= RNONE;
          r_dstM  <= RNONE;
        end else if (!wb.W_stall) begin
          r_stat  <= wb.m_stat;
          r_icode <= wb.m_icode;
          r_valE  <= wb.m_valE;
          r_valM  <= wb.m_valM;
          r_dstE  <= wb.m_dstE;
          r_dstM  <= wb.m_dstM;
        end
      end
    end
  end

  assign wb.d_rvalA    = (wb.d_srcA == RNONE) ? 64'd0 : r_rf[wb.d_srcA];
  assign wb.d_rvalB    = (wb.d_srcB == RNONE) ? 64'd0 : r_rf[wb.d_srcB];
  assign wb.W_stat     = r_stat;
  assign wb.W_icode    = r_icode;
  assign wb.W_valE     = r_valE;
  assign wb.W_valM     = r_valM;
  assign wb.W_dstE     = r_dstE;
  assign wb.W_dstM     = r_dstM;
  assign wb.stat       = r_stat;
  assign wb.halted     = r_halted;
  assign wb.retire_cnt = r_cnt;

endmodule
